// File: rtl/nios2_ls_de2_pio_key_irq.sv
`default_nettype none
// ============================================================================
// Module   : nios2_ls_de2_pio_key_irq
// Function : Avalon-MM PIO for active-low DE2 keys with falling-edge capture
//            and a level IRQ. The optional per-bit debounce filter is enabled
//            by defining PIO_KEY_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module nios2_ls_de2_pio_key_irq #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd1;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
            $error("DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef PIO_KEY_DEBOUNCE_EN
    localparam int c_CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_filt;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
            logic [c_CW-1:0] r_cnt;

            // Counter only advances while the synchronized bit disagrees with filt.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt     <= '0;
                    r_filt[i] <= 1'b1;
                end else if (r_s2[i] != r_filt[i]) begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_filt[i] <= r_s2[i];
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    endgenerate

    assign w_filt = r_filt;
`else
    assign w_filt = r_s2;
`endif

    assign w_wr   = chipselect & ~write_n;
    assign w_fall = r_prev & ~w_filt;
    assign w_clr  = (w_wr && address == c_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Set wins over clear when both hit the same bit in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= '1;
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            r_prev    <= w_filt;
            r_edgecap <= (r_edgecap & ~w_clr) | w_fall;
            if (w_wr && address == c_ADDR_MASK) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            c_ADDR_DATA: readdata[WIDTH-1:0] = w_filt;
            c_ADDR_MASK: readdata[WIDTH-1:0] = r_irqmask;
            c_ADDR_EDGE: readdata[WIDTH-1:0] = r_edgecap;
            default:     readdata = 32'd0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, writedata[31:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_nios2_ls_de2_pio_key_irq.sv
`default_nettype none
// Directed scoreboard bench for nios2_ls_de2_pio_key_irq.
module tb_nios2_ls_de2_pio_key_irq;

    localparam int WIDTH = 4;
    localparam int DB    = 8;
`ifdef PIO_KEY_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        bit          is_irq;
        logic [1:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    nios2_ls_de2_pio_key_irq #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic exp_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.is_irq = 1'b0; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input string tag, input logic v);
        exp_t e;
        e.tag = tag; e.is_irq = 1'b1; e.addr = 2'd0; e.val = {31'd0, v};
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_irq) begin
                obs = {31'd0, irq};
            end else begin
                address = e.addr;
                #1;
                obs = readdata;
            end
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        exp_reg("rst_data", 2'd0, 32'hF);
        exp_reg("rst_mask", 2'd1, 32'h0);
        exp_reg("rst_edge", 2'd3, 32'h0);
        exp_irq("rst_irq", 1'b0);
        chk();
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (i % 25 == 24) begin
                exp_irq("rst_irq_idle", 1'b0);
                exp_reg("rst_edge_idle", 2'd3, 32'h0);
                chk();
            end
        end

        // Press bit 2 with mask 0x4
        wr(2'd1, 32'h4);
        exp_reg("mask_wr", 2'd1, 32'h4);
        chk();
        in_port = 4'hB;
        tick(LAT - 1);
        exp_reg("press_early", 2'd3, 32'h0);
        exp_irq("press_early_irq", 1'b0);
        chk();
        tick(1);
        exp_reg("press_edge", 2'd3, 32'h4);
        exp_irq("press_irq", 1'b1);
        exp_reg("press_data", 2'd0, 32'hB);
        chk();
        wr(2'd3, 32'h4);
        exp_reg("clr_edge", 2'd3, 32'h0);
        exp_irq("clr_irq", 1'b0);
        chk();
        in_port = 4'hF;
        tick(LAT + 1);
        exp_reg("release_edge", 2'd3, 32'h0);
        exp_reg("release_data", 2'd0, 32'hF);
        chk();

        // Masked press on bit 1, then unmask
        wr(2'd1, 32'h1);
        in_port = 4'hD;
        tick(LAT);
        exp_reg("masked_edge", 2'd3, 32'h2);
        exp_irq("masked_irq", 1'b0);
        chk();
        wr(2'd1, 32'h3);
        exp_irq("unmask_irq", 1'b1);
        chk();
        wr(2'd3, 32'h2);
        in_port = 4'hF;
        tick(LAT + 1);
        exp_reg("masked_clr", 2'd3, 32'h0);
        exp_irq("masked_clr_irq", 1'b0);
        chk();

        // Set/clear collision on bit 0
        in_port = 4'hE;
        tick(LAT - 1);
        wr(2'd3, 32'h1);
        exp_reg("collide_edge", 2'd3, 32'h1);
        chk();
        wr(2'd3, 32'h1);
        exp_reg("collide_clr", 2'd3, 32'h0);
        chk();
        in_port = 4'h6;
        tick(LAT);
        exp_reg("bit3_edge", 2'd3, 32'h8);
        chk();
        wr(2'd3, 32'h1);
        exp_reg("partial_clr", 2'd3, 32'h8);
        chk();
        wr(2'd3, 32'h8);
        wr(2'd2, 32'hFFFF_FFFF);
        exp_reg("reserved", 2'd2, 32'h0);
        exp_reg("mask_keep", 2'd1, 32'h3);
        exp_reg("edge_zero", 2'd3, 32'h0);
        chk();
        in_port = 4'hF;
        tick(LAT + 1);

        // Reset while bit 0 is held low
        in_port = 4'hE;
        tick(5);
        reset_n = 1'b0;
        #1;
        exp_reg("rstp_edge", 2'd3, 32'h0);
        exp_reg("rstp_mask", 2'd1, 32'h0);
        chk();
        tick(2);
        reset_n = 1'b1;
        tick(LAT);
        exp_reg("rstp_capture", 2'd3, 32'h1);
        chk();
        wr(2'd3, 32'h1);
        tick(10);
        exp_reg("rstp_once", 2'd3, 32'h0);
        chk();
        in_port = 4'hF;
        tick(LAT + 5);
        exp_reg("rstp_release", 2'd3, 32'h0);
        exp_reg("rstp_data", 2'd0, 32'hF);
        chk();

`ifdef PIO_KEY_DEBOUNCE_EN
        in_port = 4'hB;
        tick(5);
        in_port = 4'hF;
        tick(20);
        exp_reg("glitch_edge", 2'd3, 32'h0);
        exp_reg("glitch_data", 2'd0, 32'hF);
        chk();
        in_port = 4'hB;
        tick(20);
        exp_reg("db_edge", 2'd3, 32'h4);
        exp_reg("db_data", 2'd0, 32'hB);
        chk();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
